// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the multi-channel pulse generator.
// Contents: run-state enum, cfg_sel register map, minimum period.
// Imported by pulse_gen_mc and pulse_chan.
package pulse_gen_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // cfg_sel map: channel c owns WIDTH_BASE+2c (width) and DELAY_BASE+2c (delay)
  localparam int CFG_PERIOD     = 0;
  localparam int CFG_BURST      = 1;
  localparam int CFG_WIDTH_BASE = 2;
  localparam int CFG_DELAY_BASE = 3;

  // Shortest period the counter will run; smaller programmed values are raised to this
  localparam int PERIOD_MIN = 2;

endpackage

// File: rtl/pulse_chan.sv
// One pulse channel: width/delay shadow + active registers and the window compare.
// Ports: clk/rst, cfg_we/cfg_sel/cfg_data (shadow writes), load (shadow->active),
//        run (gate from the period sequencer), cnt (shared period count), pulse (registered).
module pulse_chan
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DEF_WIDTH = 1000,
  parameter int CH        = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] cnt,
  output logic             pulse
);

  localparam int WSEL = CFG_WIDTH_BASE + 2 * CH;
  localparam int DSEL = CFG_DELAY_BASE + 2 * CH;

  logic [CNT_W-1:0] wid_sh, wid_act;
  logic [CNT_W-1:0] dly_sh, dly_act;
  logic [CNT_W:0]   win_end;
  logic             hit;

  // End of window at CNT_W+1 bits so a large delay+width never wraps back into range.
  // Counts past period-1 never occur, so over-long pulses are truncated at the period end.
  always_comb begin
    win_end = {1'b0, dly_act} + {1'b0, wid_act};
    hit     = (cnt >= dly_act) && ({1'b0, cnt} < win_end);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wid_sh  <= CNT_W'(DEF_WIDTH);
      wid_act <= CNT_W'(DEF_WIDTH);
      dly_sh  <= '0;
      dly_act <= '0;
      pulse   <= 1'b0;
    end else begin
      if (cfg_we && (int'(cfg_sel) == WSEL)) wid_sh <= cfg_data;
      if (cfg_we && (int'(cfg_sel) == DSEL)) dly_sh <= cfg_data;
      if (load) begin
        wid_act <= wid_sh;
        dly_act <= dly_sh;
      end
      pulse <= run && hit;
    end
  end

endmodule

// File: rtl/pulse_gen_mc.sv
// Multi-channel periodic pulse generator: one shared period counter, NUM_CH width/delay channels,
// continuous or burst mode, config shadowed and applied at period boundaries.
// Ports: clk, rst (sync, active-high), cfg_we/cfg_sel/cfg_data, mode, en, start,
//        pulse_out[NUM_CH], frame_sync, busy, done. Optional macro PULSE_POLARITY_EN adds pol_inv[NUM_CH].
module pulse_gen_mc
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int NUM_CH     = 2,
  parameter int DEF_PERIOD = 5000,
  parameter int DEF_WIDTH  = 1000,
  parameter int BURST_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [3:0]        cfg_sel,
  input  logic [CNT_W-1:0]  cfg_data,
  input  logic              mode,
  input  logic              en,
  input  logic              start,
`ifdef PULSE_POLARITY_EN
  input  logic [NUM_CH-1:0] pol_inv,
`endif
  output logic [NUM_CH-1:0] pulse_out,
  output logic              frame_sync,
  output logic              busy,
  output logic              done
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   per_sh, per_act, eff_per;
  logic [BURST_W-1:0] blen_sh, blen_act, eff_len, bcnt;
  logic               run_mode;  // mode latched at IDLE->RUN; mode changes in RUN are ignored
  logic               start_run, stop_cont, burst_end, wrap, load, run_gate;
  logic [NUM_CH-1:0]  pulse_raw;

  always_comb begin
    eff_per   = (per_act < CNT_W'(PERIOD_MIN)) ? CNT_W'(PERIOD_MIN) : per_act;
    eff_len   = (blen_act == '0) ? BURST_W'(1) : blen_act;
    wrap      = (state == RUN) && (cnt == eff_per - CNT_W'(1));
    state_nxt = state;
    start_run = 1'b0;
    stop_cont = 1'b0;
    burst_end = 1'b0;
    case (state)
      IDLE: begin
        start_run = mode ? start : en;
        if (start_run) state_nxt = RUN;
      end
      RUN: begin
        if (!run_mode && !en) begin
          stop_cont = 1'b1;
          state_nxt = IDLE;
        end else if (run_mode && wrap && (bcnt == eff_len - BURST_W'(1))) begin
          burst_end = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    load     = start_run || (wrap && (state_nxt == RUN));
    // A continuous stop blanks the outputs immediately; a burst end lets the last count finish.
    run_gate = (state == RUN) && !stop_cont;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      bcnt       <= '0;
      run_mode   <= 1'b0;
      per_sh     <= CNT_W'(DEF_PERIOD);
      per_act    <= CNT_W'(DEF_PERIOD);
      blen_sh    <= BURST_W'(1);
      blen_act   <= BURST_W'(1);
      frame_sync <= 1'b0;
      done       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cfg_we && (int'(cfg_sel) == CFG_PERIOD)) per_sh  <= cfg_data;
      if (cfg_we && (int'(cfg_sel) == CFG_BURST))  blen_sh <= cfg_data[BURST_W-1:0];
      if (load) begin
        per_act  <= per_sh;
        blen_act <= blen_sh;
      end
      if (start_run) run_mode <= mode;
      if ((state_nxt != RUN) || start_run || wrap) cnt <= '0;
      else                                         cnt <= cnt + CNT_W'(1);
      if (start_run)  bcnt <= '0;
      else if (wrap)  bcnt <= bcnt + BURST_W'(1);
      frame_sync <= run_gate && (cnt == '0);
      done       <= burst_end;
    end
  end

  assign busy = (state == RUN);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    pulse_chan #(
      .CNT_W     (CNT_W),
      .DEF_WIDTH (DEF_WIDTH),
      .CH        (c)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .cfg_we   (cfg_we),
      .cfg_sel  (cfg_sel),
      .cfg_data (cfg_data),
      .load     (load),
      .run      (run_gate),
      .cnt      (cnt),
      .pulse    (pulse_raw[c])
    );
  end

`ifdef PULSE_POLARITY_EN
  // Polarity is sampled even during reset so an inverted channel comes out of reset at its idle level 1.
  logic [NUM_CH-1:0] pol_q;
  always_ff @(posedge clk) pol_q <= pol_inv;
  assign pulse_out = pulse_raw ^ pol_q;
`else
  assign pulse_out = pulse_raw;
`endif

endmodule

// File: tb/tb_pulse_gen_mc.sv
module tb_pulse_gen_mc;

  logic        clk = 1'b0;
  logic        rst, cfg_we, mode, en, start;
  logic [3:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic [1:0]  pulse_out;
  logic        frame_sync, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pulse_gen_mc dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_sel    (cfg_sel),
    .cfg_data   (cfg_data),
    .mode       (mode),
    .en         (en),
    .start      (start),
`ifdef PULSE_POLARITY_EN
    .pol_inv    (2'b00),
`endif
    .pulse_out  (pulse_out),
    .frame_sync (frame_sync),
    .busy       (busy),
    .done       (done)
  );

  typedef struct {
    int period;     // value written to the period register
    int eff_p;      // period actually run
    int width;      // ch1 width
    int delay;      // ch1 delay
    int exp_high;   // ch1 high cycles per period
    int exp_first;  // first count at which ch1 is high, -1 if never
  } vec_t;

  localparam int NV = 8;
  vec_t vec [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wr(input int sel, input int data);
    cfg_we   = 1'b1;
    cfg_sel  = sel[3:0];
    cfg_data = data[15:0];
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; start = 1'b0; mode = 1'b0; cfg_we = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Run continuous with default config from IDLE and check 1000-high/4000-low and a 5000-cycle frame.
  task automatic check_defaults(input string tag, input bit stop_after);
    int highs, fs_cnt, fs_second;
    highs = 0; fs_cnt = 0; fs_second = -1;
    mode = 1'b0; en = 1'b1;
    tick();  // c=1
    chk({tag, "_busy_c1"}, 32'(busy), 1);
    chk({tag, "_pulse_c1"}, 32'(pulse_out[0]), 0);
    for (int k = 0; k <= 5010; k++) begin
      tick();  // c = 2 + k, shows cnt = k mod 5000
      if (k == 0) chk({tag, "_first_rise"}, 32'(pulse_out[0]), 1);
      if (k < 5000 && pulse_out[0]) highs++;
      if (frame_sync) begin
        fs_cnt++;
        if (fs_cnt == 2) fs_second = k;
      end
    end
    chk({tag, "_ch0_highs"}, 32'(highs), 1000);
    chk({tag, "_fs_count"}, 32'(fs_cnt), 2);
    chk({tag, "_fs_second"}, 32'(fs_second), 5000);
    if (stop_after) begin
      chk({tag, "_pulse_before_stop"}, 32'(pulse_out[0]), 1);
      en = 1'b0;
      tick();
      chk({tag, "_stop_pulse"}, 32'(pulse_out), 0);
      chk({tag, "_stop_busy"}, 32'(busy), 0);
      tick();
      chk({tag, "_stop_fs"}, 32'(frame_sync), 0);
    end
    en = 1'b0;
  endtask

  initial begin
    int h0, h1, first, fs_cnt, fs_first;
    int rises, highs, done_cnt, done_at, busy_fall, busy_c1;
    int fs_idx [3];
    int nfs;
    logic prev;

    vec[0] = '{100, 100, 10,    95,  5,   95};
    vec[1] = '{100, 100, 0,     0,   0,   -1};
    vec[2] = '{100, 100, 200,   0,   100, 0};
    vec[3] = '{100, 100, 10,    100, 0,   -1};
    vec[4] = '{20,  20,  5,     3,   5,   3};
    vec[5] = '{1,   2,   1,     0,   1,   0};
    vec[6] = '{2,   2,   1,     1,   1,   1};
    vec[7] = '{50,  50,  65535, 10,  40,  10};

    rst = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0; mode = 1'b0; en = 1'b0; start = 1'b0;

    // Reset state
    do_reset();
    chk("rst_pulse", 32'(pulse_out), 0);
    chk("rst_fs", 32'(frame_sync), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);

    // Defaults in continuous mode, then stop in the middle of a pulse
    check_defaults("cont", 1'b1);

    // Table: ch1 width/delay/period combinations
    for (int i = 0; i < NV; i++) begin
      do_reset();
      wr(0, vec[i].period);
      wr(4, vec[i].width);
      wr(5, vec[i].delay);
      mode = 1'b0; en = 1'b1;
      tick();  // c=1
      h0 = 0; h1 = 0; first = -1; fs_cnt = 0; fs_first = -1;
      for (int k = 0; k < 2 * vec[i].eff_p; k++) begin
        tick();
        if (pulse_out[1]) begin
          if (k < vec[i].eff_p) begin
            h0++;
            if (first < 0) first = k;
          end else begin
            h1++;
          end
        end
        if (frame_sync) begin
          fs_cnt++;
          if (fs_first < 0) fs_first = k;
        end
      end
      chk($sformatf("vec%0d_high_p0", i), 32'(h0), 32'(vec[i].exp_high));
      chk($sformatf("vec%0d_high_p1", i), 32'(h1), 32'(vec[i].exp_high));
      chk($sformatf("vec%0d_first", i), 32'(first), 32'(vec[i].exp_first));
      chk($sformatf("vec%0d_fs_count", i), 32'(fs_cnt), 2);
      chk($sformatf("vec%0d_fs_first", i), 32'(fs_first), 0);
      en = 1'b0;
      tick();
    end

    // Burst: 3 periods of 20, width 5; start re-pulsed and mode flipped mid-run must be ignored
    do_reset();
    wr(0, 20);
    wr(1, 3);
    wr(2, 5);
    mode = 1'b1; start = 1'b1;
    tick();  // c=1
    start = 1'b0;
    rises = 0; highs = 0; done_cnt = 0; done_at = -1; busy_fall = -1; busy_c1 = int'(busy);
    prev = pulse_out[0];
    for (int c = 1; c <= 70; c++) begin
      if (c > 1) tick();
      if (pulse_out[0] && !prev) rises++;
      if (pulse_out[0]) highs++;
      prev = pulse_out[0];
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (!busy && busy_fall < 0) busy_fall = c;
      if (c == 30) begin start = 1'b1; mode = 1'b0; en = 1'b0; end
      if (c == 31) start = 1'b0;
    end
    chk("burst_busy_c1", 32'(busy_c1), 1);
    chk("burst_rises", 32'(rises), 3);
    chk("burst_highs", 32'(highs), 15);
    chk("burst_done_count", 32'(done_cnt), 1);
    chk("burst_done_at", 32'(done_at), 61);
    chk("burst_busy_fall", 32'(busy_fall), 61);

    // Shadow update: period 100 -> 50 written mid-period takes effect after the current period
    do_reset();
    wr(0, 100);
    mode = 1'b0; en = 1'b1;
    tick();  // c=1
    nfs = 0;
    for (int i = 0; i < 3; i++) fs_idx[i] = -1;
    for (int c = 2; c <= 160; c++) begin
      tick();
      if (frame_sync) begin
        if (nfs < 3) fs_idx[nfs] = c;
        nfs++;
      end
      if (c == 40) begin cfg_we = 1'b1; cfg_sel = 4'd0; cfg_data = 16'd50; end
      if (c == 41) cfg_we = 1'b0;
    end
    chk("shadow_fs0", 32'(fs_idx[0]), 2);
    chk("shadow_fs1", 32'(fs_idx[1]), 102);
    chk("shadow_fs2", 32'(fs_idx[2]), 152);
    chk("shadow_fs_count", 32'(nfs), 3);
    en = 1'b0;
    tick();

    // Reset mid-burst: abort without done, config returns to defaults
    do_reset();
    wr(0, 20);
    wr(1, 3);
    mode = 1'b1; start = 1'b1;
    tick();  // c=1
    start = 1'b0;
    for (int c = 2; c <= 10; c++) tick();
    chk("midrst_pulse_before", 32'(pulse_out[0]), 1);
    rst = 1'b1;
    tick();
    chk("midrst_pulse", 32'(pulse_out), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    rst = 1'b0;
    done_cnt = 0; highs = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (done) done_cnt++;
      if (busy) highs++;
    end
    chk("midrst_no_done", 32'(done_cnt), 0);
    chk("midrst_stays_idle", 32'(highs), 0);
    check_defaults("postrst", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
